// File: rtl/conv_pad_streamer.sv
// conv_pad_streamer
// Producer side of the conv2d_layer1 pixel stream. It takes raster-order
// 8-bit pixels over valid/ready and emits a padded stream. Every row gets
// PADDING zeros on the left and on the right. After the last row,
// FLUSH_ROWS full rows of zeros follow to drain the consumer pipeline.
//
// Optional feature: define CONV_PAD_TOP_EN to emit PADDING full zero rows
// before the first row. In the default build there are no top rows.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle frame request, honoured only in IDLE
//   s_valid    upstream pixel valid
//   s_data     upstream pixel (unsigned 8-bit)
//   s_ready    combinational, high only while accepting pixels
//   out_valid  registered beat valid, goes to conv2d_layer1.in_valid
//   out_data   registered beat data, goes to conv2d_layer1.in_data
//   busy       registered, high from the cycle after start through the last beat
//   done       registered one-cycle pulse after the last beat
module conv_pad_streamer #(
  parameter int PADDING    = 1,
  parameter int IMG_W      = 4,
  parameter int IMG_H      = 4,
  parameter int FLUSH_ROWS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
);

  localparam int ROW_W = IMG_W + 2 * PADDING;
  localparam int CW    = $clog2(ROW_W + 1);
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FN    = (FLUSH_ROWS > PADDING) ? FLUSH_ROWS : PADDING;
  localparam int FW    = (FN > 1) ? $clog2(FN) : 1;

  localparam logic [CW-1:0] PAD_LAST   = CW'((PADDING > 0) ? PADDING - 1 : 0);
  localparam logic [CW-1:0] PIX_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] WIDE_LAST  = CW'(ROW_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_ROWS > 0) ? FLUSH_ROWS - 1 : 0);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LPAD  = 3'd2;
  localparam logic [2:0] PIX   = 3'd3;
  localparam logic [2:0] RPAD  = 3'd4;
  localparam logic [2:0] FLUSH = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [2:0] ROW_ENTRY  = (PADDING > 0) ? LPAD : PIX;
  localparam logic [2:0] AFTER_ROWS = (FLUSH_ROWS > 0) ? FLUSH : DONE;

`ifdef CONV_PAD_TOP_EN
  localparam logic [2:0] TOP      = 3'd1;
  localparam logic [FW-1:0] TOP_LAST = FW'((PADDING > 0) ? PADDING - 1 : 0);
  localparam logic [2:0] FIRST_ST = (PADDING > 0) ? TOP : ROW_ENTRY;
`else
  localparam logic [2:0] FIRST_ST = ROW_ENTRY;
`endif

  logic [2:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] frow;
  logic          row_done;

  assign s_ready = (state == PIX);

  // A row closes either at the last right pad or, with no padding, at the
  // last accepted pixel. Both cases share the row-advance logic below.
  always_comb begin
    row_done = 1'b0;
    if (state == RPAD && col == PAD_LAST)
      row_done = 1'b1;
    if (PADDING == 0 && state == PIX && s_valid && col == PIX_LAST)
      row_done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      frow      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      case (state)
        IDLE: begin
          // The IDLE cycle that carries the done pulse does not take a new
          // start, so the earliest restart is the cycle after done.
          if (start && !done) begin
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
            frow  <= '0;
            state <= FIRST_ST;
          end
        end
`ifdef CONV_PAD_TOP_EN
        TOP: begin
          out_valid <= 1'b1;
          if (col == WIDE_LAST) begin
            col <= '0;
            if (frow == TOP_LAST) begin
              frow  <= '0;
              state <= LPAD;
            end else begin
              frow <= frow + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
`endif
        LPAD: begin
          out_valid <= 1'b1;
          if (col == PAD_LAST) begin
            col   <= '0;
            state <= PIX;
          end else begin
            col <= col + 1'b1;
          end
        end
        PIX: begin
          if (s_valid) begin
            out_valid <= 1'b1;
            out_data  <= s_data;
            if (col == PIX_LAST) begin
              col   <= '0;
              state <= RPAD;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        RPAD: begin
          out_valid <= 1'b1;
          if (col == PAD_LAST) col <= '0;
          else                 col <= col + 1'b1;
        end
        FLUSH: begin
          out_valid <= 1'b1;
          if (col == WIDE_LAST) begin
            col <= '0;
            if (frow == FLUSH_LAST) begin
              frow  <= '0;
              state <= DONE;
            end else begin
              frow <= frow + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Overrides the per-state next state at the end of a row.
      if (row_done) begin
        if (row == ROW_LAST) begin
          state <= AFTER_ROWS;
        end else begin
          row   <= row + 1'b1;
          state <= ROW_ENTRY;
        end
      end
    end
  end

endmodule
